// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Sequencing controller for the multi-cycle 32-bit core. Each instruction held
// in the IR is walked through FETCH -> DECODE -> EXEC -> MEM -> WB (skipping the
// phases its class does not need). The controller also drives the datapath
// strobes, waits on the instruction/data memory ready handshakes, gives up with
// a timeout, honours the stop bit and counts retired instructions.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   instruction  current IR contents: [31]=stop, [30:29]=type, [4:0]=opcode
//   zero         ALU zero flag, used by BEQ in EXEC
//   imem_ready   instruction memory has data valid this cycle
//   dmem_ready   data memory has completed the access this cycle
//   imem_req     instruction fetch request
//   ir_write     load the IR
//   pc_write     update the PC
//   pc_src       PC source: 01 = PC+1, 10 = jump concat, 11 = branch target
//   dmem_req     data memory request
//   mem_read     data memory read (LW)
//   mem_write    data memory write (SW)
//   reg_write    register file write enable
//   link_sel     writeback data = PC (JAL link)
//   state        current state, for debug
//   halted       sticky, set when the stop bit retires
//   illegal      sticky, set on an illegal instruction
//   timeout      sticky, set on a memory timeout
//   instret      retired-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             dmem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             link_sel,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERROR  = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        C_ALU,   // R ALU, I ALU-imm and S shift all take the EXEC -> WB path
        C_LW,
        C_SW,
        C_BEQ,
        C_J,
        C_JAL,
        C_ILL
    } iclass_e;

    localparam logic [1:0] PC_PLUS1  = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_BRANCH = 2'b11;

    // The wait counter only has to reach TIMEOUT-1: the timeout fires on the
    // cycle that would otherwise increment past it.
    localparam int              WC_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic             retire;

    logic [1:0] i_type;
    logic [4:0] i_op;
    iclass_e    iclass;

    assign i_type = instruction[30:29];
    assign i_op   = instruction[4:0];

    // Operand/immediate fields are consumed by the datapath, not here.
    logic unused_ir_bits;
    assign unused_ir_bits = ^instruction[28:5];

    // -------------------------------------------------------------------------
    // Instruction class decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        iclass = C_ILL;
        case (i_type)
            2'b00, 2'b11: begin
                if (i_op <= 5'd3) iclass = C_ALU;
            end
            2'b10: begin
                case (i_op)
                    5'd0, 5'd1: iclass = C_ALU;
                    5'd2:       iclass = C_LW;
                    5'd3:       iclass = C_SW;
                    5'd4:       iclass = C_BEQ;
                    default:    iclass = C_ILL;
                endcase
            end
            default: begin // 2'b01, jump class
                case (i_op)
                    5'd0:    iclass = C_J;
                    5'd1:    iclass = C_JAL;
                    default: iclass = C_ILL;
                endcase
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register and counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
        if (!rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            instret_q  <= '0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            instret_q  <= instret_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and strobes
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        instret_d  = instret_q;
        halted_d   = halted_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        retire     = 1'b0;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        dmem_req   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        link_sel   = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                imem_req = 1'b1;
                // Ready wins over the timeout, so data on the last allowed
                // cycle is still accepted.
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_PLUS1;
                    state_d  = S_DECODE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = S_ERROR;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            S_DECODE: begin
                case (iclass)
                    C_ILL: begin
                        state_d   = S_ERROR;
                        illegal_d = 1'b1;
                    end
                    C_J: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                        retire   = 1'b1;
                    end
                    C_JAL: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                        state_d  = S_WB;
                    end
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                case (iclass)
                    C_LW, C_SW: state_d = S_MEM;
                    C_BEQ: begin
                        pc_src   = PC_BRANCH;
                        pc_write = zero;
                        retire   = 1'b1;
                    end
                    default: state_d = S_WB;
                endcase
            end

            S_MEM: begin
                dmem_req  = 1'b1;
                mem_read  = (iclass == C_LW);
                mem_write = (iclass == C_SW);
                if (dmem_ready) begin
                    if (iclass == C_LW) state_d = S_WB;
                    else                retire  = 1'b1;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = S_ERROR;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                link_sel  = (iclass == C_JAL);
                retire    = 1'b1;
            end

            default: ; // HALT and ERROR hold until reset
        endcase

        // Retire is the cycle that leaves an instruction's final state; the
        // stop bit decides whether the core keeps fetching.
        if (retire) begin
            instret_d = instret_q + 1'b1;
            state_d   = instruction[31] ? S_HALT : S_FETCH;
        end

        if (state_d == S_HALT) halted_d = 1'b1;

        // Every FETCH or MEM visit starts with a fresh wait budget.
        if (state_d != state_q) wait_cnt_d = '0;
    end

    assign state   = state_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Self-checking bench for multicycle_control_fsm. Each instruction is expanded
// by an instruction-level reference model into the list of phases it must go
// through (fetch waits, decode, exec, memory waits, writeback) with the strobes
// each phase must show; the bench drives the ready/zero inputs for every cycle
// and compares the DUT outputs cycle by cycle, then compares the counters and
// sticky flags after each instruction.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;

    typedef enum int { C_ALU, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL } cls_e;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       dmem_req;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       link_sel;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      instruction = '0;
    logic             zero = 1'b0;
    logic             imem_ready = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             imem_req;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             dmem_req;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             link_sel;
    logic [2:0]       state;
    logic             halted;
    logic             illegal;
    logic             timeout;
    logic [CNT_W-1:0] instret;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int exp_instret = 0;
    bit exp_halted  = 1'b0;
    bit exp_illegal = 1'b0;
    bit exp_timeout = 1'b0;
    bit need_idle   = 1'b1;

    always #5 clk = ~clk;

    multicycle_control_fsm #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instruction(instruction),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .dmem_req   (dmem_req),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .link_sel   (link_sel),
        .state      (state),
        .halted     (halted),
        .illegal    (illegal),
        .timeout    (timeout),
        .instret    (instret)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic obs_t mk(input logic [2:0] st);
        obs_t o;
        o    = '0;
        o.st = st;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.st        = state;
        o.imem_req  = imem_req;
        o.ir_write  = ir_write;
        o.pc_write  = pc_write;
        o.pc_src    = pc_src;
        o.dmem_req  = dmem_req;
        o.mem_read  = mem_read;
        o.mem_write = mem_write;
        o.reg_write = reg_write;
        o.link_sel  = link_sel;
        return o;
    endfunction

    // Highest legal opcode for each instruction type.
    function automatic int max_op(input logic [1:0] ty);
        case (ty)
            2'b00:   return 3;
            2'b10:   return 4;
            2'b01:   return 1;
            default: return 3;
        endcase
    endfunction

    function automatic cls_e classify(input logic [31:0] ins);
        logic [1:0] ty;
        int         op;
        ty = ins[30:29];
        op = int'(ins[4:0]);
        if (op > max_op(ty)) return C_ILL;
        if (ty == 2'b01) return (op == 0) ? C_J : C_JAL;
        if (ty == 2'b10) begin
            if (op == 2) return C_LW;
            if (op == 3) return C_SW;
            if (op == 4) return C_BEQ;
        end
        return C_ALU;
    endfunction

    function automatic logic [31:0] mk_instr(input logic stop, input logic [1:0] ty, input logic [4:0] op);
        logic [23:0] mid;
        mid = 24'($urandom);
        return {stop, ty, mid, op};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [1:0] ty;
        logic [4:0] op;
        logic       stop;
        ty   = 2'($urandom_range(0, 3));
        stop = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 9) == 0) op = 5'($urandom);
        else                           op = 5'($urandom_range(0, max_op(ty)));
        return mk_instr(stop, ty, op);
    endfunction

    function automatic int rand_wait();
        int r;
        r = int'($urandom_range(0, 39));
        if (r < 34) return r % 4;
        if (r < 36) return TIMEOUT - 1;
        if (r == 36) return TIMEOUT;
        return 0;
    endfunction

    // One clock cycle: drive inputs, compare outputs at the falling edge,
    // then advance to just after the next rising edge.
    task automatic step(input string tag, input obs_t exp, input logic im_r, input logic dm_r, input logic z);
        imem_ready = im_r;
        dmem_ready = dm_r;
        zero       = z;
        @(negedge clk);
        check(tag, 32'(observe()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_instret"}, 32'(instret), 32'(exp_instret % (1 << CNT_W)));
        check({tag, "_flags"}, 32'({halted, illegal, timeout}), 32'({exp_halted, exp_illegal, exp_timeout}));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_outputs", 32'(observe()), 32'(0));
        check("rst_counters", 32'({instret, halted, illegal, timeout}), 32'(0));
        exp_instret = 0;
        exp_halted  = 1'b0;
        exp_illegal = 1'b0;
        exp_timeout = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b1;
        need_idle = 1'b1;
    endtask

    // Terminal states ignore all inputs and keep every strobe low.
    task automatic dwell(input logic [2:0] st);
        for (int k = 0; k < 4; k++) step("terminal", mk(st), rb(), rb(), rb());
        check_counters("terminal");
    endtask

    // Run one instruction through the reference model. abort_at >= 0 pulls
    // reset after that many not-ready MEM cycles.
    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input logic z, input int abort_at);
        cls_e c;
        obs_t e;
        bit   err;
        c   = classify(ins);
        err = 1'b0;
        instruction = ins;

        if (need_idle) begin
            step("idle", mk(3'd0), rb(), rb(), rb());
            need_idle = 1'b0;
        end

        e = mk(3'd1);
        e.imem_req = 1'b1;
        for (int k = 0; k < iw && k < TIMEOUT; k++) step("fetch_wait", e, 1'b0, rb(), rb());
        if (iw >= TIMEOUT) begin
            err         = 1'b1;
            exp_timeout = 1'b1;
        end else begin
            e.ir_write = 1'b1;
            e.pc_write = 1'b1;
            e.pc_src   = 2'b01;
            step("fetch_go", e, 1'b1, rb(), rb());
            e = mk(3'd2);
            if (c == C_ILL) begin
                step("decode_ill", e, rb(), rb(), rb());
                err         = 1'b1;
                exp_illegal = 1'b1;
            end else begin
                if (c == C_J || c == C_JAL) begin
                    e.pc_write = 1'b1;
                    e.pc_src   = 2'b10;
                end
                step("decode", e, rb(), rb(), rb());
            end
        end

        if (!err && (c == C_ALU || c == C_LW || c == C_SW || c == C_BEQ)) begin
            e = mk(3'd3);
            if (c == C_BEQ) begin
                e.pc_src   = 2'b11;
                e.pc_write = z;
            end
            step("exec", e, rb(), rb(), z);
        end

        if (!err && (c == C_LW || c == C_SW)) begin
            e = mk(3'd4);
            e.dmem_req  = 1'b1;
            e.mem_read  = (c == C_LW);
            e.mem_write = (c == C_SW);
            for (int k = 0; k < dw && k < TIMEOUT; k++) begin
                if (k == abort_at) begin
                    do_reset();
                    return;
                end
                step("mem_wait", e, rb(), 1'b0, rb());
            end
            if (dw >= TIMEOUT) begin
                err         = 1'b1;
                exp_timeout = 1'b1;
            end else begin
                step("mem_go", e, rb(), 1'b1, rb());
            end
        end

        if (!err && (c == C_ALU || c == C_LW || c == C_JAL)) begin
            e = mk(3'd5);
            e.reg_write = 1'b1;
            e.link_sel  = (c == C_JAL);
            step("wb", e, rb(), rb(), rb());
        end

        if (!err) begin
            exp_instret++;
            if (ins[31]) exp_halted = 1'b1;
        end

        check_counters("retire");
        check("next_state", 32'(state), err ? 32'd7 : (ins[31] ? 32'd6 : 32'd1));

        if (err || ins[31]) begin
            dwell(err ? 3'd7 : 3'd6);
            do_reset();
        end
    endtask

    initial begin
        #1;
        do_reset();

        // ADD, all ready: IDLE, FETCH, DECODE, EXEC, WB, back to FETCH
        run_instr(mk_instr(1'b0, 2'b00, 5'd0), 0, 0, 1'b0, -1);
        // LW with three not-ready data cycles
        run_instr(mk_instr(1'b0, 2'b10, 5'd2), 0, 3, 1'b0, -1);
        // BEQ taken, then not taken
        run_instr(mk_instr(1'b0, 2'b10, 5'd4), 0, 0, 1'b1, -1);
        run_instr(mk_instr(1'b0, 2'b10, 5'd4), 0, 0, 1'b0, -1);
        // JAL with stop: link writeback then HALT
        run_instr(mk_instr(1'b1, 2'b01, 5'd1), 0, 0, 1'b0, -1);
        // Illegal R-type op 5
        run_instr(mk_instr(1'b0, 2'b00, 5'd5), 0, 0, 1'b0, -1);
        // Fetch timeout and the last-cycle-ready boundary
        run_instr(mk_instr(1'b0, 2'b00, 5'd1), TIMEOUT, 0, 1'b0, -1);
        run_instr(mk_instr(1'b0, 2'b00, 5'd1), TIMEOUT - 1, 0, 1'b0, -1);
        // Data memory boundary and timeout on SW
        run_instr(mk_instr(1'b0, 2'b10, 5'd3), 1, TIMEOUT - 1, 1'b0, -1);
        run_instr(mk_instr(1'b0, 2'b10, 5'd3), 0, TIMEOUT, 1'b0, -1);
        // J retires from DECODE
        run_instr(mk_instr(1'b0, 2'b01, 5'd0), 2, 0, 1'b0, -1);
        // Reset dropped in the middle of MEM
        run_instr(mk_instr(1'b0, 2'b10, 5'd2), 0, 5, 1'b0, 2);

        for (int n = 0; n < 400; n++) begin
            run_instr(rand_instr(), rand_wait(), rand_wait(), rb(), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multi-cycle build of the 32-bit core. It walks each instruction held in the IR through FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes.
- Handles the instruction- and data-memory ready handshakes, including a timeout.
- Honours the stop bit (instruction[31]) and counts retired instructions.
- Field decoding (type = [30:29], opcode = [4:0]) matches the decode stage. ALUOp generation stays in the existing ALU controller.

Parameters:
- TIMEOUT, 16: maximum consecutive not-ready cycles in FETCH or MEM before the ERROR state.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- instruction  in  32  current IR contents; stable from DECODE until retire.
- zero  in  1  ALU zero flag, sampled in EXEC for branches.
- imem_ready  in  1  instruction memory has data valid this cycle.
- dmem_ready  in  1  data memory has completed the access this cycle.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load the IR.
- pc_write  out  1  update the PC.
- pc_src  out  2  PC source: 01 = PC+1, 10 = jump concat, 11 = branch target.
- dmem_req  out  1  data memory request.
- mem_read  out  1  data memory read.
- mem_write  out  1  data memory write.
- reg_write  out  1  register file write enable.
- link_sel  out  1  writeback data = PC (JAL link).
- state  out  3  current state, for debug.
- halted  out  1  sticky; set on stop.
- illegal  out  1  sticky; set on illegal instruction.
- timeout  out  1  sticky; set on memory timeout.
- instret  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7.
- Reset: while rst=0, state=IDLE; instret, wait_cnt and the sticky flags are 0. All outputs are 0 during reset and in IDLE. Reset asserted mid-instruction aborts immediately, with no retire.
- IDLE: go to FETCH on the next clock, unconditionally.
- Decode classes (type, op):
  - R (00): ops 0-3 are ALU.
  - I (10): ops 0-1 ALU-imm, 2 LW, 3 SW, 4 BEQ.
  - J (01): op 0 J, op 1 JAL.
  - S (11): ops 0-3 are shift.
  - Any other op is illegal.
- FETCH:
  - imem_req=1.
  - If imem_ready=1: ir_write=1, pc_write=1, pc_src=01, next state DECODE.
  - If not ready: wait_cnt increments. When wait_cnt==TIMEOUT-1 with ready still 0, go to ERROR and set timeout.
  - Ready is checked first, so ready on the final allowed cycle still proceeds.
- DECODE:
  - Illegal op: go to ERROR, set illegal, no strobes.
  - J: pc_write=1, pc_src=10, then retire.
  - JAL: pc_write=1, pc_src=10, next state WB.
  - All other classes: next state EXEC.
- EXEC:
  - ALU, ALU-imm, shift: next state WB.
  - LW, SW: next state MEM.
  - BEQ: pc_src=11, pc_write=zero, then retire.
- MEM:
  - dmem_req=1; mem_read=1 for LW, mem_write=1 for SW. Both are held until dmem_ready.
  - Timeout rule is the same as FETCH.
  - When ready: LW goes to WB; SW retires.
- WB: reg_write=1 for exactly one cycle; link_sel=1 for JAL. Then retire.
- wait_cnt clears on every entry to FETCH or MEM.
- Retire (the cycle that leaves an instruction's final state):
  - instret increments in that cycle.
  - Next state is HALT if instruction[31]=1, otherwise FETCH.
- HALT: halted=1, all strobes 0, inputs ignored; only reset exits.
- ERROR: all strobes 0, sticky flags held, instret frozen; only reset exits.
- Output timing:
  - Strobes are combinational from state, IR and ready.
  - pc_write/ir_write are asserted in at most one cycle per state visit.
  - reg_write and mem_write are never asserted together.

Test Plan:
- Reset, then ADD (type 00, op 0, stop 0) with imem_ready=1 → state sequence 0,1,2,3,5,1; reg_write high only in WB; instret=1.
- LW (type 10, op 2) with dmem_ready low for 3 cycles → mem_read=dmem_req=1 for 4 cycles, then WB with reg_write=1; instret=1.
- BEQ (type 10, op 4): zero=1 → EXEC pc_write=1, pc_src=11; repeat with zero=0 → pc_write=0; both return to FETCH.
- JAL (type 01, op 1) with stop=1 → DECODE pc_write=1, pc_src=10; WB reg_write=link_sel=1; then HALT, halted=1, instret=1; later imem_ready pulses leave imem_req=0.
- Illegal R-type op 5 → ERROR, illegal=1, no reg_write or pc_write in DECODE, instret unchanged.
- imem_ready held 0 with TIMEOUT=16 → ERROR after exactly 16 FETCH cycles, timeout=1. Separately, drop rst during MEM → all outputs 0 immediately, state=0.
